// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch_queue front end.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc_plus1;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Circular prefetch buffer holding {pc_plus1, instr} entries.
// Pointers wrap for free because DEPTH is a power of two.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fq_entry_t                wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output fq_entry_t                head
);

  localparam int PW = $clog2(DEPTH);

  fq_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign full  = (cnt == (PW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, imem addressing and prefetch queue.
// Optional FETCH_QUEUE_BYPASS_EN forwards imem_data straight out when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_data,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [ADDR_W-1:0]        out_pc_plus1,
  output logic [$clog2(DEPTH):0]   count
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic              fifo_full;
  logic              fifo_empty;
  logic              queued_valid;
  logic              bypass;
  logic              pop;
  logic              fetch;
  logic              push;
  fq_entry_t         push_entry;
  fq_entry_t         head;

  assign pc_plus1  = pc + 32'd1;
  assign imem_addr = pc;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = fifo_empty & ~redirect_valid & out_ready;
`else
  assign bypass = 1'b0;
`endif

  // A redirect hides the head and blocks both pop and fetch for that cycle.
  assign queued_valid = ~fifo_empty & ~redirect_valid;
  assign out_valid    = queued_valid | bypass;
  assign pop          = queued_valid & out_ready;
  assign fetch        = ~redirect_valid & (~fifo_full | pop);
  assign push         = fetch & ~bypass;

  assign push_entry.pc_plus1 = pc_plus1;
  assign push_entry.instr    = imem_data;

  always_comb begin
    out_instr    = NOP_INSTR;
    out_pc_plus1 = '0;
    if (bypass) begin
      out_instr    = imem_data;
      out_pc_plus1 = pc_plus1;
    end else if (queued_valid) begin
      out_instr    = head.instr;
      out_pc_plus1 = head.pc_plus1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_target;
    else if (fetch)          pc <= pc_plus1;
  end

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .wdata (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count),
    .head  (head)
  );

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the program counter, addresses the combinational instruction memory, and buffers fetched words with their PC+1 in a small prefetch queue. The queue decouples fetch from decode stalls and lets a branch or jump redirect flush the buffered path in one cycle.

## Interface
- DEPTH, 4: queue entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000: PC loaded on reset
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- imem_addr  out  32  word address to instruction memory (equals PC)
- imem_data  in  32  instruction at imem_addr, same cycle (combinational memory)
- redirect_valid  in  1  branch/jump taken; flush queue and load target
- redirect_target  in  32  new PC when redirect_valid=1
- out_valid  out  1  head entry valid toward IF/ID
- out_ready  in  1  IF/ID accepts head this cycle
- out_instr  out  32  head instruction
- out_pc_plus1  out  32  head PC+1 (word-addressed increment)
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Entry = {pc_plus1[31:0], instr[31:0]}. Queue is a circular buffer with read/write pointers that wrap modulo DEPTH.
- pop = out_valid & out_ready & ~redirect_valid.
- fetch = ~redirect_valid & (count < DEPTH | pop). On fetch: push {pc+1, imem_data} and set pc ← pc+1. PC wraps 0xFFFF_FFFF → 0.
- Simultaneous push and pop on a full queue is legal; count stays DEPTH.
- Simultaneous push and pop on an empty queue cannot occur without the bypass (out_valid=0); see Configuration.
- Redirect has priority over fetch and pop: pointers and count are cleared, pc ← redirect_target, no push and no pop. out_valid is forced to 0 during the redirect cycle.
- rst has priority over everything, including redirect: pc ← RESET_PC, pointers and count ← 0.
- When out_valid=0, out_instr and out_pc_plus1 drive 0.
- Reset values: imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc_plus1=0, count=0.

## Timing
- Fetch-to-output latency is 1 cycle: a word fetched in cycle N appears at the head in cycle N+1 if the queue was empty.
- After redirect in cycle R:
  - R+1: imem_addr=target, out_valid=0.
  - R+2: head = target instruction, with out_pc_plus1 = target+1.
- First valid output after reset release is 2 cycles (fetch of RESET_PC, then head).
- With out_ready held high, throughput is 1 instruction/cycle. imem_addr holds when the queue is full and there is no pop.
- count updates on the edge following the push/pop decision.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count=0, no redirect, and out_ready=1, imem_data is presented combinationally this cycle:
  - out_valid=1, out_instr=imem_data, out_pc_plus1=pc+1.
  - The word is consumed without a push, and pc advances.
  - Fetch-to-output latency becomes 0 cycles; after redirect, the target is output in R+1.
- Undefined: no combinational path from imem_data to the out_* ports; all latencies as in Timing.

## Structure
- Shared package fetch_pkg:
  - fq_entry_t struct {pc_plus1, instr}
  - INSTR_W=32, ADDR_W=32
  - NOP_INSTR=32'h0000_0000
- One sub-module, fq_fifo: parameterised DEPTH circular buffer (push, pop, clear, full, empty, count, head). PC logic, fetch/pop decision and bypass stay in fetch_queue.

## Test plan
- Reset: assert rst 2 cycles → imem_addr=0, out_valid=0, count=0, out_instr=0.
- Streaming: memory model returns 0x2000_0000|addr, out_ready=1 → from the 2nd cycle after reset, out_valid=1 every cycle with out_instr 0x2000_0000, 0x2000_0001, … and out_pc_plus1 1, 2, ….
- Backpressure: out_ready=0 for 10 cycles → count saturates at 4 and imem_addr holds at 4. Release → 4 entries drain in order (pc_plus1 1..4), then streaming resumes from addr 4 with no gap or duplicate.
- Redirect: at count=3, pulse redirect_valid with target 0x40 → next cycle count=0, out_valid=0, imem_addr=0x40. The cycle after: out_instr=0x2000_0040, out_pc_plus1=0x41.
- Priority: rst and redirect_valid (target 0x80) in the same cycle → imem_addr=RESET_PC next cycle. Redirect while out_ready=1 → no pop recorded, out_valid=0.
- Bypass (FETCH_QUEUE_BYPASS_EN): empty queue, out_ready=1, redirect to 0x10 in cycle R → out_valid=1, out_instr=0x2000_0010 in R+1, count stays 0.
